preview_queue_mapper: RTL and testbench

- Parametrised successor to the single next-piece and swap-piece pixel mappers.
- Owns the upcoming-piece queue (NUM_SLOTS deep) and the hold register, including the handshakes with game logic.
- Renders all queue slots plus the hold slot as a registered, two-stage pixel pipeline that feeds the colour mapper.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/piece_mask_rom.sv | 24 ++
 rtl/preview_queue_mapper.sv | 185 ++++++++++++++++++
 tb/tb_preview_queue_mapper.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece definitions: 3-bit piece type, type constants and the 4x4
// spawn-orientation masks (bit r*4+c, c=0 leftmost, r=0 top).
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam piece_t PIECE_I    = 3'd0;
    localparam piece_t PIECE_O    = 3'd1;
    localparam piece_t PIECE_T    = 3'd2;
    localparam piece_t PIECE_S    = 3'd3;
    localparam piece_t PIECE_Z    = 3'd4;
    localparam piece_t PIECE_J    = 3'd5;
    localparam piece_t PIECE_L    = 3'd6;
    localparam piece_t PIECE_NONE = 3'd7;

    localparam int MASK_W = 4;

    localparam logic [15:0] MASK_I = 16'h00F0;
    localparam logic [15:0] MASK_O = 16'h0066;
    localparam logic [15:0] MASK_T = 16'h0072;
    localparam logic [15:0] MASK_S = 16'h0036;
    localparam logic [15:0] MASK_Z = 16'h0063;
    localparam logic [15:0] MASK_J = 16'h0071;
    localparam logic [15:0] MASK_L = 16'h0074;

endpackage

// File: rtl/piece_mask_rom.sv
// Combinational lookup from piece type to its 4x4 spawn mask; type 7 is blank.
module piece_mask_rom
    import tetris_pkg::*;
(
    input  logic [2:0]  i_type,
    output logic [15:0] o_mask
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_mask = '0;
        case (piece_t'(i_type))
            PIECE_I: o_mask = MASK_I;
            PIECE_O: o_mask = MASK_O;
            PIECE_T: o_mask = MASK_T;
            PIECE_S: o_mask = MASK_S;
            PIECE_Z: o_mask = MASK_Z;
            PIECE_J: o_mask = MASK_J;
            PIECE_L: o_mask = MASK_L;
            default: o_mask = '0;
        endcase
    end

endmodule

// File: rtl/preview_queue_mapper.sv
// Upcoming-piece queue and hold register with their game handshakes, plus a
// two-stage pixel pipeline that renders every queue slot and the hold slot.
module preview_queue_mapper
    import tetris_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int CELL_PX    = 20,
    parameter int SLOT_X0    = 6,
    parameter int SLOT_Y0    = 4,
    parameter int SLOT_PITCH = 5,
    parameter int HOLD_X0    = 26,
    parameter int HOLD_Y0    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       push_valid,
    input  logic [2:0] push_type,
    output logic       push_ready,
    input  logic       pop,
    output logic       head_valid,
    output logic [2:0] head_type,
    output logic [2:0] queue_count,
    input  logic       swap_req,
    input  logic [2:0] cur_type,
    output logic       swap_ack,
    output logic       swap_nack,
    output logic       swap_from_queue,
    output logic [2:0] swap_type,
    input  logic       lock_clear,
    output logic       hold_valid,
    output logic       is_preview,
    output logic [2:0] preview_type,
    output logic       is_hold_px
);

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_SLOTS - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] slot_idx(input logic [PW-1:0] rd, input int k);
        int s;
        s = int'(rd) + k;
        if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
        return PW'(s);
    endfunction

    function automatic logic in_window(input logic [9:0] cx, input logic [9:0] cy,
                                       input int x0, input int y0);
        return (int'(cx) >= x0) && (int'(cx) < x0 + MASK_W) &&
               (int'(cy) >= y0) && (int'(cy) < y0 + MASK_W);
    endfunction

    piece_t          r_mem [NUM_SLOTS];
    logic [PW-1:0]   r_rd, r_wr;
    logic [2:0]      r_count;
    piece_t          r_hold;
    logic            r_hold_valid, r_lock;
    logic            r_ack, r_nack, r_from_q;
    piece_t          r_swap_type;
    logic [9:0]      r_cx, r_cy;
    logic            r_is_preview, r_is_hold_px;
    piece_t          r_preview_type;

    logic            w_push, w_pop;
    logic            w_sel_hit, w_sel_hold, w_px_on;
    piece_t          w_sel_type;
    logic [1:0]      w_sel_row, w_sel_col;
    logic [15:0]     w_mask;

    assign push_ready = (r_count < 3'(NUM_SLOTS));
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && (r_count != 3'd0);

    // NOTE: queue storage has no reset; empty slots are never rendered or reported, so their contents are don't-care.
    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wr] <= piece_t'(push_type);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (w_push) r_wr <= next_ptr(r_wr);
            if (w_pop)  r_rd <= next_ptr(r_rd);
            if (w_push && !w_pop)      r_count <= r_count + 3'd1;
            else if (w_pop && !w_push) r_count <= r_count - 3'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_lock       <= 1'b0;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
            r_from_q     <= 1'b0;
            r_swap_type  <= '0;
        end else begin
            r_ack    <= 1'b0;
            r_nack   <= 1'b0;
            r_from_q <= 1'b0;
            if (swap_req) begin
                if (r_lock) begin
                    r_nack <= 1'b1;
                end else begin
                    r_ack        <= 1'b1;
                    r_from_q     <= !r_hold_valid;
                    if (r_hold_valid) r_swap_type <= r_hold;
                    r_hold       <= piece_t'(cur_type);
                    r_hold_valid <= 1'b1;
                    r_lock       <= 1'b1;
                end
            end
            // Landing re-arms hold even if a swap was accepted this same cycle.
            if (lock_clear) r_lock <= 1'b0;
        end
    end

    always_comb begin
        w_sel_hit  = 1'b0;
        w_sel_hold = 1'b0;
        w_sel_type = '0;
        w_sel_row  = '0;
        w_sel_col  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (k < int'(r_count) && in_window(r_cx, r_cy, SLOT_X0, SLOT_Y0 + k * SLOT_PITCH)) begin
                w_sel_hit  = 1'b1;
                w_sel_type = r_mem[slot_idx(r_rd, k)];
                w_sel_row  = 2'(int'(r_cy) - (SLOT_Y0 + k * SLOT_PITCH));
                w_sel_col  = 2'(int'(r_cx) - SLOT_X0);
            end
        end
        if (r_hold_valid && in_window(r_cx, r_cy, HOLD_X0, HOLD_Y0)) begin
            w_sel_hit  = 1'b1;
            w_sel_hold = 1'b1;
            w_sel_type = r_hold;
            w_sel_row  = 2'(int'(r_cy) - HOLD_Y0);
            w_sel_col  = 2'(int'(r_cx) - HOLD_X0);
        end
    end

    piece_mask_rom u_mask_rom (
        .i_type (w_sel_type),
        .o_mask (w_mask)
    );

    assign w_px_on = w_sel_hit && w_mask[{w_sel_row, w_sel_col}];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cx           <= '0;
            r_cy           <= '0;
            r_is_preview   <= 1'b0;
            r_is_hold_px   <= 1'b0;
            r_preview_type <= '0;
        end else begin
            r_cx           <= 10'(DrawX / CELL_PX);
            r_cy           <= 10'(DrawY / CELL_PX);
            r_is_preview   <= w_px_on;
            r_is_hold_px   <= w_px_on && w_sel_hold;
            r_preview_type <= w_px_on ? w_sel_type : '0;
        end
    end

    assign head_valid      = (r_count != 3'd0);
    assign head_type       = head_valid ? r_mem[r_rd] : 3'd0;
    assign queue_count     = r_count;
    assign swap_ack        = r_ack;
    assign swap_nack       = r_nack;
    assign swap_from_queue = r_from_q;
    assign swap_type       = r_swap_type;
    assign hold_valid      = r_hold_valid;
    assign is_preview      = r_is_preview;
    assign preview_type    = r_preview_type;
    assign is_hold_px      = r_is_hold_px;

endmodule

// File: tb/tb_preview_queue_mapper.sv
// Directed bench for preview_queue_mapper: queue, hold handshake, pixel
// rendering and asynchronous reset, with hand-computed expectations.
module tb_preview_queue_mapper;

    logic       Clk, Reset;
    logic [9:0] DrawX, DrawY;
    logic       push_valid, push_ready, pop, head_valid;
    logic [2:0] push_type, head_type, queue_count;
    logic       swap_req, swap_ack, swap_nack, swap_from_queue, lock_clear, hold_valid;
    logic [2:0] cur_type, swap_type, preview_type;
    logic       is_preview, is_hold_px;

    int checks = 0;
    int errors = 0;

    preview_queue_mapper dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .push_valid      (push_valid),
        .push_type       (push_type),
        .push_ready      (push_ready),
        .pop             (pop),
        .head_valid      (head_valid),
        .head_type       (head_type),
        .queue_count     (queue_count),
        .swap_req        (swap_req),
        .cur_type        (cur_type),
        .swap_ack        (swap_ack),
        .swap_nack       (swap_nack),
        .swap_from_queue (swap_from_queue),
        .swap_type       (swap_type),
        .lock_clear      (lock_clear),
        .hold_valid      (hold_valid),
        .is_preview      (is_preview),
        .preview_type    (preview_type),
        .is_hold_px      (is_hold_px)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        step();
    endtask

    initial begin
        Reset = 1'b0; DrawX = '0; DrawY = '0;
        push_valid = 1'b0; push_type = '0; pop = 1'b0;
        swap_req = 1'b0; cur_type = '0; lock_clear = 1'b0;
        step();
        step();
        check("rst_push_ready", int'(push_ready), 1);
        check("rst_count",      int'(queue_count), 0);
        check("rst_head_valid", int'(head_valid), 0);
        check("rst_hold_valid", int'(hold_valid), 0);
        check("rst_is_preview", int'(is_preview), 0);
        Reset = 1'b1;
        step();

        // Push O, then probe cell (7,5) = slot 0 r1 c1 and cell (6,5) = r1 c0.
        push_valid = 1'b1; push_type = 3'd1;
        DrawX = 10'd150; DrawY = 10'd110;
        step();
        push_valid = 1'b0;
        check("push1_count", int'(queue_count), 1);
        check("push1_head",  int'(head_type), 1);
        step();
        check("o_px_on",   int'(is_preview), 1);
        check("o_px_type", int'(preview_type), 1);
        check("o_px_hold", int'(is_hold_px), 0);
        pixel(130, 110);
        check("o_px_off",      int'(is_preview), 0);
        check("o_px_off_type", int'(preview_type), 0);

        // Drain, then fill with I,O,T (rd=wr=1 so writes wrap).
        pop = 1'b1; step(); pop = 1'b0;
        check("drain_count", int'(queue_count), 0);
        push_valid = 1'b1;
        push_type = 3'd0; step();
        push_type = 3'd1; step();
        push_type = 3'd2; step();
        check("full_ready", int'(push_ready), 0);
        check("full_count", int'(queue_count), 3);
        push_type = 3'd6; step();
        push_valid = 1'b0;
        check("drop_count", int'(queue_count), 3);
        check("drop_head",  int'(head_type), 0);
        pixel(150, 110);
        check("slot0_I_type", int'(preview_type), 0);
        check("slot0_I_on",   int'(is_preview), 1);
        pixel(150, 300);
        check("slot2_T_type", int'(preview_type), 2);
        pop = 1'b1; step(); pop = 1'b0;
        check("pop_head",  int'(head_type), 1);
        check("pop_count", int'(queue_count), 2);
        pixel(150, 110);
        check("slot0_O_type", int'(preview_type), 1);

        // Simultaneous pop + push(J) at count 2: rd wraps 2->0, head becomes T.
        pop = 1'b1; push_valid = 1'b1; push_type = 3'd5;
        step();
        pop = 1'b0; push_valid = 1'b0;
        check("pp_count", int'(queue_count), 2);
        check("pp_head",  int'(head_type), 2);
        pixel(150, 200);
        check("slot1_J_on",   int'(is_preview), 1);
        check("slot1_J_type", int'(preview_type), 5);
        pixel(150, 300);
        check("slot2_blank", int'(is_preview), 0);

        // Hold handshake.
        swap_req = 1'b1; cur_type = 3'd3; step(); swap_req = 1'b0;
        check("sw1_ack",   int'(swap_ack), 1);
        check("sw1_fromq", int'(swap_from_queue), 1);
        check("sw1_hold",  int'(hold_valid), 1);
        check("sw1_nack",  int'(swap_nack), 0);
        step();
        check("sw1_pulse", int'(swap_ack), 0);
        swap_req = 1'b1; cur_type = 3'd6; step(); swap_req = 1'b0;
        check("sw2_nack", int'(swap_nack), 1);
        check("sw2_ack",  int'(swap_ack), 0);
        lock_clear = 1'b1; step(); lock_clear = 1'b0;
        swap_req = 1'b1; cur_type = 3'd4; step(); swap_req = 1'b0;
        check("sw3_ack",   int'(swap_ack), 1);
        check("sw3_fromq", int'(swap_from_queue), 0);
        check("sw3_type",  int'(swap_type), 3);
        // Locked swap with lock_clear same cycle: refused, but lock is released.
        swap_req = 1'b1; lock_clear = 1'b1; cur_type = 3'd2; step();
        lock_clear = 1'b0;
        check("sw4_nack", int'(swap_nack), 1);
        step(); swap_req = 1'b0;
        check("sw5_ack",  int'(swap_ack), 1);
        check("sw5_type", int'(swap_type), 4);

        // Hold slot now holds T: (27,5) is r1 c1 filled, (29,4) is r0 c3 blank.
        pixel(550, 110);
        check("hold_px_on",   int'(is_preview), 1);
        check("hold_px_hold", int'(is_hold_px), 1);
        check("hold_px_type", int'(preview_type), 2);
        pixel(590, 90);
        check("hold_px_off", int'(is_preview), 0);
        pixel(550, 110);

        // Asynchronous reset mid-queue and mid-swap.
        lock_clear = 1'b1; step(); lock_clear = 1'b0;
        swap_req = 1'b1; cur_type = 3'd3; step(); swap_req = 1'b0;
        check("pre_rst_ack", int'(swap_ack), 1);
        check("pre_rst_px",  int'(is_preview), 1);
        #2 Reset = 1'b0;
        #1;
        check("arst_ack",        int'(swap_ack), 0);
        check("arst_fromq",      int'(swap_from_queue), 0);
        check("arst_swap_type",  int'(swap_type), 0);
        check("arst_count",      int'(queue_count), 0);
        check("arst_ready",      int'(push_ready), 1);
        check("arst_head_valid", int'(head_valid), 0);
        check("arst_head_type",  int'(head_type), 0);
        check("arst_hold_valid", int'(hold_valid), 0);
        check("arst_is_preview", int'(is_preview), 0);
        check("arst_type",       int'(preview_type), 0);
        check("arst_hold_px",    int'(is_hold_px), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
